// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a separate sign fix-up state.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        f3;
  logic              neg_res;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;   // product; low half doubles as dividend/quotient
  logic [XLEN-1:0]   opb;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   rem;

  logic              is_div, a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, ovf;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   diff;
  logic              take;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  // Handshake: start is sampled only in IDLE; busy covers the accept cycle through FIX,
  // done is a single-cycle pulse decoded from DONE, and flush returns to IDLE from anywhere.
  assign busy      = (state == ST_IDLE) ? start : ((state == ST_CALC) || (state == ST_FIX));
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_comb begin
    is_div = funct3[2];
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                         a_sgn = 1'b1;
      default: ;
    endcase
    neg_a    = a_sgn & rs1[XLEN-1];
    neg_b    = b_sgn & rs2[XLEN-1];
    mag_a    = neg_a ? (~rs1 + 1'b1) : rs1;
    mag_b    = neg_b ? (~rs2 + 1'b1) : rs2;
    div_zero = is_div && (rs2 == '0);
    ovf      = is_div && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
    fast_res = '0;
    if (div_zero)
      fast_res = funct3[1] ? rs1 : '1;
    else if (ovf)
      fast_res = funct3[1] ? '0 : MIN_NEG;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    shifted  = {rem, acc[XLEN-1]};
    take     = (shifted >= {1'b0, opb});
    diff     = shifted[XLEN-1:0] - opb;
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quo_fix  = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg_res ? (~rem + 1'b1) : rem;
    case (f3)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      f3      <= '0;
      neg_res <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      rem     <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            f3      <= funct3;
            neg_res <= (is_div && funct3[1]) ? neg_a : (neg_a ^ neg_b);
            cnt     <= '0;
            rem     <= '0;
            if (div_zero || ovf) begin
              result <= fast_res;
              state  <= ST_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
              opb   <= is_div ? mag_b : mag_a;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (f3[2]) begin
            rem <= take ? diff : shifted[XLEN-1:0];
            acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], take};
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == {CNT_W{1'b1}})
            state <= ST_FIX;
        end
        ST_FIX: begin
          result <= fix_result;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table of RV32M ops with hand-computed results,
// plus sequences for reset, flush and ignored starts.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          bexp;
  } vec_t;

  vec_t vt[16];

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy), .done(done), .result(result), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called at a point away from the edge while the DUT is idle; drives start immediately.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcyc);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    lat = -1; bcyc = 0;
    #1 if (busy) bcyc++;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcyc++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int lat, bcyc, seen;

    vt[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 34};
    vt[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 34};
    vt[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 34};
    vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 34};
    vt[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 34};
    vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 34};
    vt[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34, 34};
    vt[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34, 34};
    vt[8]  = '{3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1,  1};
    vt[9]  = '{3'b110, 32'h1234,     32'd0,        32'h1234,     1,  1};
    vt[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1};
    vt[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1};
    vt[12] = '{3'b001, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 34, 34};
    vt[13] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 34};
    vt[14] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 34};
    vt[15] = '{3'b011, 32'h00010000, 32'h00010000, 32'd1,        34, 34};

    // Clock/reset
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table, issued back-to-back
    for (int i = 0; i < 16; i++) begin
      run_op(vt[i].f, vt[i].a, vt[i].b, res, lat, bcyc);
      chk($sformatf("v%0d_result", i), res, vt[i].exp);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bcyc, vt[i].bexp);
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_single", i), {31'd0, done}, 32'd0);
    end

    // start during CALC is ignored; a start held into DONE is ignored too
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFFFFFD;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) begin funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; end
      #1;
      if (done) begin lat = i; break; end
    end
    chk("ignored_start_latency", lat, 34);
    chk("ignored_start_result", result, 32'hFFFFFFEB);
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_in_done_state", {30'd0, state_dbg}, 32'd0);
    chk("start_in_done_busy", {31'd0, busy}, 32'd0);

    // flush together with start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_state", {30'd0, state_dbg}, 32'd0);
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    // flush mid-divide: no done, result kept
    @(negedge clk);
    run_op(3'b111, 32'd100, 32'd7, res, lat, bcyc);
    chk("pre_flush_result", res, 32'd2);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1 = 32'd500; rs2 = 32'd9;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    #1 chk("flush_cycle_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("after_flush_busy", {31'd0, busy}, 32'd0);
    chk("after_flush_state", {30'd0, state_dbg}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1 if (done) seen++;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_result_kept", result, 32'd2);

    // reset mid-CALC aborts with no done
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1 if (done) seen++;
    end
    chk("midreset_no_done", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
